// File: rtl/sync_pkg.sv
// Shared constants and types for the multi-stage level synchronizer.
package sync_pkg;

  localparam int SYNC_MIN_STAGES     = 2;
  localparam int SYNC_DEFAULT_STAGES = 2;

  typedef struct packed {
    logic rise;
    logic fall;
  } sync_edge_t;

  function automatic sync_edge_t sync_edge(input logic cur, input logic prev);
    sync_edge_t e;
    e.rise = cur & ~prev;
    e.fall = ~cur & prev;
    return e;
  endfunction

endpackage

// File: rtl/sync_bit_chain.sv
// One-bit STAGES-deep flop chain with async active-low reset to RESET_BIT.
module sync_bit_chain
  import sync_pkg::*;
#(
  parameter int   STAGES    = SYNC_DEFAULT_STAGES,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  // Chain flops are placed together and excluded from retiming by the tools.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_stage;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stage <= {STAGES{RESET_BIT}};
    end else begin
      r_stage <= {r_stage[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/data_synchronizer.sv
// LEN-bit level synchronizer built from independent per-bit flop chains.
// Optional SYNCHRONIZER_EDGE_DETECT_EN adds one-cycle riseOut/fallOut pulses.
module data_synchronizer
  import sync_pkg::*;
#(
  parameter int             LEN         = 2,
  parameter int             STAGES      = SYNC_DEFAULT_STAGES,
  parameter logic [LEN-1:0] RESET_VALUE = '0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [LEN-1:0] dataIn,
`ifdef SYNCHRONIZER_EDGE_DETECT_EN
  output logic [LEN-1:0] riseOut,
  output logic [LEN-1:0] fallOut,
`endif
  output logic [LEN-1:0] dataOut
);

  if (STAGES < SYNC_MIN_STAGES || LEN < 1) begin : g_param_err
    $error("data_synchronizer: need STAGES >= %0d and LEN >= 1", SYNC_MIN_STAGES);
  end

  logic [LEN-1:0] w_sync;

  for (genvar i = 0; i < LEN; i++) begin : g_bit
    sync_bit_chain #(
      .STAGES    (STAGES),
      .RESET_BIT (RESET_VALUE[i])
    ) u_chain (
      .clk     (clk),
      .reset_n (reset_n),
      .i_d     (dataIn[i]),
      .o_q     (w_sync[i])
    );
  end

  assign dataOut = w_sync;

`ifdef SYNCHRONIZER_EDGE_DETECT_EN
  logic [LEN-1:0]         r_data_out_q;
  sync_edge_t [LEN-1:0]   w_edge;

  // Resetting to RESET_VALUE keeps the first post-reset cycle pulse-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out_q <= RESET_VALUE;
    end else begin
      r_data_out_q <= w_sync;
    end
  end

  for (genvar i = 0; i < LEN; i++) begin : g_edge
    assign w_edge[i]  = sync_edge(w_sync[i], r_data_out_q[i]);
    assign riseOut[i] = w_edge[i].rise;
    assign fallOut[i] = w_edge[i].fall;
  end
`endif

endmodule

// File: tb/tb_data_synchronizer.sv
// Directed self-checking bench: 2-stage instance plus a 4-stage instance with a nonzero reset value.
module tb_data_synchronizer;

  logic       clk;
  logic       clk_run;
  logic       reset_n;
  logic [1:0] data_in;
  logic [1:0] data_out;
  logic [1:0] data_in4;
  logic [1:0] data_out4;
`ifdef SYNCHRONIZER_EDGE_DETECT_EN
  logic [1:0] rise_out, fall_out, rise_out4, fall_out4;
`endif

  int n_cmp;
  int n_err;

  data_synchronizer #(.LEN(2), .STAGES(2)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dataIn  (data_in),
`ifdef SYNCHRONIZER_EDGE_DETECT_EN
    .riseOut (rise_out),
    .fallOut (fall_out),
`endif
    .dataOut (data_out)
  );

  data_synchronizer #(.LEN(2), .STAGES(4), .RESET_VALUE(2'b10)) u_dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .dataIn  (data_in4),
`ifdef SYNCHRONIZER_EDGE_DETECT_EN
    .riseOut (rise_out4),
    .fallOut (fall_out4),
`endif
    .dataOut (data_out4)
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    clk_run  = 1'b0;
    reset_n  = 1'b1;
    data_in  = 2'b11;
    data_in4 = 2'b01;

    // 1: reset with no clock running
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_out", {30'd0, data_out}, 32'd0);
    check("rst_async_out4", {30'd0, data_out4}, 32'd2);
`ifdef SYNCHRONIZER_EDGE_DETECT_EN
    check("rst_rise", {30'd0, rise_out}, 32'd0);
    check("rst_fall", {30'd0, fall_out}, 32'd0);
`endif
    clk_run = 1'b1;
    tick(3);
    check("rst_hold_out", {30'd0, data_out}, 32'd0);
    check("rst_hold_out4", {30'd0, data_out4}, 32'd2);
    data_in  = 2'b00;
    data_in4 = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    tick(4);
    check("settle_out", {30'd0, data_out}, 32'd0);
    check("settle_out4", {30'd0, data_out4}, 32'd0);

    // 2: 0 -> 3, two-edge latency
    data_in = 2'b11;
    tick(1);
    check("rise_e1", {30'd0, data_out}, 32'd0);
    tick(1);
    check("rise_e2", {30'd0, data_out}, 32'd3);

    // 3: 3 -> 0, then hold
    data_in = 2'b00;
    tick(1);
    check("fall_e1", {30'd0, data_out}, 32'd3);
    tick(1);
    check("fall_e2", {30'd0, data_out}, 32'd0);
    tick(3);
    check("fall_hold", {30'd0, data_out}, 32'd0);

    // 4: four-stage latency
    data_in4 = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      check($sformatf("stg4_e%0d", k), {30'd0, data_out4}, (k >= 4) ? 32'd1 : 32'd0);
    end

    // 5a: reset with a settled nonzero output clears it at once
    data_in = 2'b11;
    tick(2);
    check("pre_rst_out", {30'd0, data_out}, 32'd3);
    reset_n = 1'b0;
    #1;
    check("rst_immediate", {30'd0, data_out}, 32'd0);
    check("rst_immediate4", {30'd0, data_out4}, 32'd2);
    #2 reset_n = 1'b1;
    tick(1);
    check("post_rst_e1", {30'd0, data_out}, 32'd0);
    tick(1);
    check("post_rst_e2", {30'd0, data_out}, 32'd3);

    // 5b: reset mid-flight discards the captured value
    data_in = 2'b00;
    tick(3);
    data_in = 2'b11;
    tick(1);
    reset_n = 1'b0;
    #1;
    check("midflight_rst", {30'd0, data_out}, 32'd0);
    #2 reset_n = 1'b1;
    tick(1);
    check("midflight_e1", {30'd0, data_out}, 32'd0);
    tick(1);
    check("midflight_e2", {30'd0, data_out}, 32'd3);

`ifdef SYNCHRONIZER_EDGE_DETECT_EN
    // 6: bit0 pulse, count one-cycle strobes
    begin
      int rise0, fall0, other, rise_at;
      rise0 = 0; fall0 = 0; other = 0; rise_at = -1;
      data_in = 2'b00;
      tick(4);
      data_in = 2'b01;
      for (int k = 1; k <= 12; k++) begin
        tick(1);
        if (k == 3) data_in = 2'b00;
        if (rise_out[0]) begin rise0++; rise_at = k; end
        if (fall_out[0]) fall0++;
        if (rise_out[1] || fall_out[1]) other++;
      end
      check("edge_rise_cnt", rise0, 32'd1);
      check("edge_fall_cnt", fall0, 32'd1);
      check("edge_rise_at", rise_at, 32'd2);
      check("edge_bit1_quiet", other, 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
